sram_access_ctrl: RTL

- Two-port arbiter and access sequencer for the 64-word SRAM macro.
- Accepts read/write requests from two masters and arbitrates them round-robin.
- Drives each access through a precharge, wordline and sense sequence.
- Outputs feed the 6-to-64 active-low wordline decoder, the precharge devices, the write drivers and the sense amplifiers.

---
 rtl/sram_access_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sram_access_ctrl.sv
// Two-master round-robin arbiter and precharge/wordline/sense sequencer for the
// 64-word SRAM macro. Every output is a flop: the array-facing strobes, the
// busy flag and the done pulses show the state of the previous cycle, and the
// grant pulse is set on the same edge that latches the request. As a result
// the wordline decoder and the masters never see a combinational path.
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// PRE   | bitline precharge, PRE_CYCLES cycles
// WL    | wordline on (write drivers on for a write), WL_CYCLES cycles
// SENSE | sense amps fire for a read; nothing is driven for a write
// RESP  | done pulse to the winning master is scheduled
module sram_access_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int PRE_CYCLES = 1,
  parameter int WL_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] arr_addr,
  output logic              arr_pre_n,
  output logic              arr_wl_en_n,
  output logic              arr_we,
  output logic [DATA_W-1:0] arr_wdata,
  output logic              arr_sae,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, PRE, WL, SENSE, RESP} state_t;

  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] WL_LOAD  = 4'(WL_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        pre_cnt, pre_cnt_nxt;
  logic [3:0]        wl_cnt, wl_cnt_nxt;
  logic              rr_ptr;      // 1: master 1 wins the next tie
  logic              win;         // id of the master being served
  logic              we_l;
  logic [DATA_W-1:0] wdata_l;
  logic              grant_any;
  logic              grant_id;

  // Round-robin pick; only meaningful while IDLE
  always_comb begin
    grant_any = (state == IDLE) && (m0_req || m1_req);
    grant_id  = (m0_req && m1_req) ? rr_ptr : m1_req;
  end

  // Next-state and phase-counter logic
  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    wl_cnt_nxt  = wl_cnt;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt   = PRE;
          pre_cnt_nxt = PRE_LOAD;
        end
      end
      PRE: begin
        if (pre_cnt == 4'd0) begin
          state_nxt  = WL;
          wl_cnt_nxt = WL_LOAD;
        end else begin
          pre_cnt_nxt = pre_cnt - 4'd1;
        end
      end
      WL: begin
        if (wl_cnt == 4'd0) state_nxt = SENSE;
        else                wl_cnt_nxt = wl_cnt - 4'd1;
      end
      SENSE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and phase counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre_cnt <= 4'd0;
      wl_cnt  <= 4'd0;
    end else begin
      state   <= state_nxt;
      pre_cnt <= pre_cnt_nxt;
      wl_cnt  <= wl_cnt_nxt;
    end
  end

  // Latch the winning request and move the round-robin pointer on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      win      <= 1'b0;
      we_l     <= 1'b0;
      wdata_l  <= '0;
      arr_addr <= '0;
    end else if (grant_any) begin
      rr_ptr   <= ~grant_id;
      win      <= grant_id;
      we_l     <= grant_id ? m1_we    : m0_we;
      wdata_l  <= grant_id ? m1_wdata : m0_wdata;
      arr_addr <= grant_id ? m1_addr  : m0_addr;
    end
  end

  // Registered grant, array strobes, done pulses and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      arr_pre_n   <= 1'b1;
      arr_wl_en_n <= 1'b1;
      arr_we      <= 1'b0;
      arr_wdata   <= '0;
      arr_sae     <= 1'b0;
      m0_done     <= 1'b0;
      m1_done     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      m0_gnt      <= grant_any && !grant_id;
      m1_gnt      <= grant_any && grant_id;
      arr_pre_n   <= (state != PRE);
      arr_wl_en_n <= (state != WL);
      arr_we      <= (state == WL) && we_l;
      arr_wdata   <= ((state == WL) && we_l) ? wdata_l : '0;
      arr_sae     <= (state == SENSE) && !we_l;
      m0_done     <= (state == RESP) && !win;
      m1_done     <= (state == RESP) && win;
      busy        <= (state != IDLE);
    end
  end

  // Capture sensed data at the end of the sense-enable cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (arr_sae) begin
      if (win) m1_rdata <= arr_rdata;
      else     m0_rdata <= arr_rdata;
    end
  end

endmodule
